systolic_mem_responder: RTL and testbench
=========================================

// Module: systolic_mem_responder
// PURPOSE
//  Memory-side responder for the systolic core's word-serial memory port.
//  Serves reads at act_addr with fixed latency; accepts C writeback words.
//  Has a host streaming port that preloads the A/B regions before a run.
//  Sits between SystolicTemp and the board/host; exports access counters and an error flag.
// PARAMETERS
//  WIDTH        16    data word width (signed two's complement, stored raw)
//  ADDR_W       12    address width; must match act_addr
//  DEPTH        4096  implemented words; DEPTH <= 2**ADDR_W
//  READ_LATENCY 1     core read latency in cycles; legal range 1..4
// PORTS
//  clk           in   1         single clock, rising edge
//  rst           in   1         asynchronous, active-high reset
//  core_addr     in   ADDR_W    word address from core (act_addr)
//  core_rd_en    in   1         read request, one word per cycle
//  core_rd_data  out  WIDTH     read data to core (mem_read)
//  core_rd_valid out  1         core_rd_data valid this cycle
//  core_wr_en    in   1         writeback strobe
//  core_wr_data  in   WIDTH     writeback word
//  host_start    in   1         start load burst (sampled in MR_IDLE only)
//  host_base     in   ADDR_W    burst base address (sampled at start)
//  host_len      in   ADDR_W+1  burst length in words, 0..2**ADDR_W
//  host_data     in   WIDTH     load word
//  host_valid    in   1         host_data valid
//  host_ready    out  1         responder accepts host_data
//  load_done     out  1         one-cycle pulse, burst finished
//  busy          out  1         1 while in MR_LOAD
//  rd_count      out  32        accepted core reads, saturating
//  wr_count      out  32        accepted core + host writes, saturating
//  err_addr      out  1         sticky: out-of-range or collision event
// BEHAVIOUR
//  Reset: all outputs 0; FSM to MR_IDLE; read pipe flushed; RAM contents NOT cleared.
//  FSM MR_IDLE -> MR_LOAD on host_start when host_len != 0; host_len == 0 -> load_done pulse next cycle, stay MR_IDLE.
//  MR_LOAD: host_ready = 1; each host_valid&host_ready writes host_data at base+idx, idx++.
//  Accepting word idx == host_len-1 -> MR_IDLE; load_done pulses the following cycle.
//  host_start while MR_LOAD is ignored. Load address base+idx >= DEPTH: word dropped, err_addr set, idx still advances.
//  Core read accepted only in MR_IDLE: data of mem[core_addr] appears READ_LATENCY cycles later with core_rd_valid = 1.
//  Back-to-back reads give one valid word per cycle, in order.
//  Core write accepted only in MR_IDLE: mem[core_addr] <= core_wr_data at that edge.
//  Read and write in the same cycle, same address: read returns OLD data (read-before-write).
//  Core rd/wr in MR_LOAD: request dropped, no valid, err_addr set.
//  Core address >= DEPTH: read returns 0 with valid; write dropped; err_addr set.
//  Counters: +1 per accepted access; saturate at 32'hFFFF_FFFF; never wrap.
//  err_addr clears only on rst.
//  Reset mid-load: burst abandoned, no load_done; already-written words persist.
// STRUCTURE
//  SystolicTypes package gains: mem_resp_state_t {MR_IDLE, MR_LOAD}; MR_MAX_READ_LATENCY = 4.
//  Sub-module systolic_sram: simple dual-port RAM, 1 write port, 1 registered read port.
//  This module owns the extra latency stages, FSM, counters and error logic.
// TESTING
//  1 Host load base=0,len=4,data 1,2,3,4 -> load_done pulses once; core reads 0..3 return 1,2,3,4.
//  2 Read latency: LAT=1 and LAT=3; back-to-back reads of addr 0..15 -> valid exactly LAT cycles after each request, in order.
//  3 Same-cycle rd+wr addr 5 (old 7, new -3) -> read returns 7; next read returns -3; wr_count +1.
//  4 Core read during MR_LOAD -> no core_rd_valid; err_addr = 1; rd_count unchanged.
//  5 DEPTH=32, read addr 40 -> data 0 with valid; write to addr 40 dropped; err_addr = 1.
//  6 rst asserted after 2 of 4 load words -> busy = 0, no load_done; words 0..1 readable, host_ready = 0.

Source files
------------

// File: rtl/systolic_mem_responder_pkg.sv
// Shared types and constants for the systolic core's memory-side responder.
package systolic_mem_responder_pkg;

    typedef enum logic {
        MR_IDLE = 1'b0,
        MR_LOAD = 1'b1
    } mem_resp_state_t;

    localparam int MR_MAX_READ_LATENCY = 4;

    // Saturating increment for the 32-bit access counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/systolic_mem_responder_sram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module systolic_sram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4096,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [MEM_AW-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset; host-loaded data
    // must survive a reset, and a resettable array would not map onto block RAM.
    // The same-edge read sees the old word, giving read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data      <= mem[rd_addr];
    end

endmodule

// File: rtl/systolic_mem_responder.sv
// Memory responder: host burst loader FSM, fixed-latency core read pipe,
// core writeback, saturating access counters and a sticky error flag.
module systolic_mem_responder
    import systolic_mem_responder_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int ADDR_W       = 12,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_rd_en,
    output logic [WIDTH-1:0]  core_rd_data,
    output logic              core_rd_valid,
    input  logic              core_wr_en,
    input  logic [WIDTH-1:0]  core_wr_data,
    input  logic              host_start,
    input  logic [ADDR_W-1:0] host_base,
    input  logic [ADDR_W:0]   host_len,
    input  logic [WIDTH-1:0]  host_data,
    input  logic              host_valid,
    output logic              host_ready,
    output logic              load_done,
    output logic              busy,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic              err_addr
);

    localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    mem_resp_state_t   state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              load_done_q, load_done_d;
    logic [31:0]       rd_count_q, rd_count_d;
    logic [31:0]       wr_count_q, wr_count_d;
    logic              err_q, err_d;
    logic              oob_q, oob_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;

    logic [ADDR_W:0]   host_addr;
    logic              core_oob;
    logic              rd_accept;
    logic              ram_we;
    logic [MEM_AW-1:0] ram_waddr;
    logic [WIDTH-1:0]  ram_wdata;
    logic [WIDTH-1:0]  ram_rdata;
    logic [WIDTH-1:0]  stage0_data;
    logic [WIDTH-1:0]  rd_data_out;

    assign host_addr = {1'b0, base_q} + idx_q;
    assign core_oob  = ({1'b0, core_addr} >= DEPTH_W);

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        load_done_d = 1'b0;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_d       = err_q;
        oob_d       = 1'b0;
        rd_accept   = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = core_addr[MEM_AW-1:0];
        ram_wdata   = core_wr_data;

        case (state_q)
            MR_IDLE: begin
                if (host_start) begin
                    if (host_len != '0) begin
                        state_d = MR_LOAD;
                        base_d  = host_base;
                        len_d   = host_len;
                        idx_d   = '0;
                    end else begin
                        load_done_d = 1'b1;
                    end
                end
                if (core_rd_en) begin
                    rd_accept  = 1'b1;
                    oob_d      = core_oob;
                    rd_count_d = sat_inc(rd_count_q);
                    if (core_oob) err_d = 1'b1;
                end
                if (core_wr_en) begin
                    if (core_oob) begin
                        err_d = 1'b1;
                    end else begin
                        ram_we     = 1'b1;
                        wr_count_d = sat_inc(wr_count_q);
                    end
                end
            end
            MR_LOAD: begin
                // The core port is locked out for the whole burst.
                if (core_rd_en || core_wr_en) err_d = 1'b1;
                if (host_valid) begin
                    idx_d     = idx_q + 1'b1;
                    ram_waddr = host_addr[MEM_AW-1:0];
                    ram_wdata = host_data;
                    if (host_addr >= DEPTH_W) begin
                        err_d = 1'b1;
                    end else begin
                        ram_we     = 1'b1;
                        wr_count_d = sat_inc(wr_count_q);
                    end
                    if (idx_q == len_q - 1'b1) begin
                        state_d     = MR_IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end
            default: state_d = MR_IDLE;
        endcase
    end

    always_comb begin
        vld_d[0] = rd_accept;
        for (int k = 1; k < READ_LATENCY; k++) vld_d[k] = vld_q[k-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MR_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            load_done_q <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_q       <= 1'b0;
            oob_q       <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            load_done_q <= load_done_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_q       <= err_d;
            oob_q       <= oob_d;
            vld_q       <= vld_d;
        end
    end

    systolic_sram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .MEM_AW (MEM_AW)
    ) u_sram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (rd_accept && !core_oob),
        .rd_addr (core_addr[MEM_AW-1:0]),
        .rd_data (ram_rdata)
    );

    // Out-of-range reads and idle cycles present zero on the data bus.
    assign stage0_data = (vld_q[0] && !oob_q) ? ram_rdata : '0;

    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_data_out = stage0_data;
    end else begin : g_latn
        logic [WIDTH-1:0] dly_q [READ_LATENCY-1];
        logic [WIDTH-1:0] dly_d [READ_LATENCY-1];

        always_comb begin
            dly_d[0] = stage0_data;
            for (int k = 1; k < READ_LATENCY - 1; k++) dly_d[k] = dly_q[k-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < READ_LATENCY - 1; k++) dly_q[k] <= '0;
            end else begin
                dly_q <= dly_d;
            end
        end

        assign rd_data_out = dly_q[READ_LATENCY-2];
    end

    assign core_rd_data  = rd_data_out;
    assign core_rd_valid = vld_q[READ_LATENCY-1];
    assign host_ready    = (state_q == MR_LOAD);
    assign busy          = (state_q == MR_LOAD);
    assign load_done     = load_done_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;
    assign err_addr      = err_q;

endmodule

// File: tb/tb_systolic_mem_responder.sv
// Bench for systolic_mem_responder: two instances (full depth/latency 1 and
// depth 32/latency 3) share stimulus and are checked against a word-level model.
module tb_systolic_mem_responder;

    localparam int DEPTH_A = 4096;
    localparam int DEPTH_B = 32;
    localparam int LAT_A   = 1;
    localparam int LAT_B   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] core_addr = '0;
    logic        core_rd_en = 1'b0;
    logic        core_wr_en = 1'b0;
    logic [15:0] core_wr_data = '0;
    logic        host_start = 1'b0;
    logic [11:0] host_base = '0;
    logic [12:0] host_len = '0;
    logic [15:0] host_data = '0;
    logic        host_valid = 1'b0;

    logic [15:0] core_rd_data_a, core_rd_data_b;
    logic        core_rd_valid_a, core_rd_valid_b;
    logic        host_ready_a, host_ready_b;
    logic        load_done_a, load_done_b;
    logic        busy_a, busy_b;
    logic [31:0] rd_count_a, rd_count_b, wr_count_a, wr_count_b;
    logic        err_addr_a, err_addr_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: word arrays with written-flags, plain access counts.
    logic [15:0] mem_a [DEPTH_A];
    bit          known_a [DEPTH_A];
    logic [15:0] mem_b [DEPTH_B];
    bit          known_b [DEPTH_B];
    int          rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
    bit          err_a_m = 0, err_b_m = 0;

    logic [15:0] load_buf [64];
    bit          op_rd [64];
    bit          op_wr [64];
    int          op_addr [64];
    logic [15:0] op_data [64];

    always #5 clk = ~clk;

    systolic_mem_responder #(.WIDTH(16), .ADDR_W(12), .DEPTH(DEPTH_A), .READ_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .core_addr(core_addr), .core_rd_en(core_rd_en),
        .core_rd_data(core_rd_data_a), .core_rd_valid(core_rd_valid_a),
        .core_wr_en(core_wr_en), .core_wr_data(core_wr_data),
        .host_start(host_start), .host_base(host_base), .host_len(host_len),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready_a),
        .load_done(load_done_a), .busy(busy_a), .rd_count(rd_count_a),
        .wr_count(wr_count_a), .err_addr(err_addr_a));

    systolic_mem_responder #(.WIDTH(16), .ADDR_W(12), .DEPTH(DEPTH_B), .READ_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .core_addr(core_addr), .core_rd_en(core_rd_en),
        .core_rd_data(core_rd_data_b), .core_rd_valid(core_rd_valid_b),
        .core_wr_en(core_wr_en), .core_wr_data(core_wr_data),
        .host_start(host_start), .host_base(host_base), .host_len(host_len),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready_b),
        .load_done(load_done_b), .busy(busy_b), .rd_count(rd_count_b),
        .wr_count(wr_count_b), .err_addr(err_addr_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input int addr, input logic [15:0] d);
        if (addr < DEPTH_A) begin mem_a[addr] = d; known_a[addr] = 1; wr_a++; end
        else err_a_m = 1;
        if (addr < DEPTH_B) begin mem_b[addr] = d; known_b[addr] = 1; wr_b++; end
        else err_b_m = 1;
    endfunction

    function automatic void model_read(input int addr, output logic [15:0] da, output bit ka,
                                       output logic [15:0] db, output bit kb);
        rd_a++;
        rd_b++;
        if (addr < DEPTH_A) begin da = mem_a[addr]; ka = known_a[addr]; end
        else begin da = '0; ka = 1; err_a_m = 1; end
        if (addr < DEPTH_B) begin db = mem_b[addr]; kb = known_b[addr]; end
        else begin db = '0; kb = 1; err_b_m = 1; end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({core_rd_data_a, core_rd_valid_a, host_ready_a, load_done_a, busy_a,
             rd_count_a, wr_count_a, err_addr_a} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_a: got data=%h v=%b rdy=%b done=%b busy=%b rc=%0d wc=%0d err=%b, want all 0",
                     core_rd_data_a, core_rd_valid_a, host_ready_a, load_done_a, busy_a,
                     rd_count_a, wr_count_a, err_addr_a);
        end
        vectors++;
        if ({core_rd_data_b, core_rd_valid_b, host_ready_b, load_done_b, busy_b,
             rd_count_b, wr_count_b, err_addr_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_b: got data=%h v=%b rdy=%b done=%b busy=%b rc=%0d wc=%0d err=%b, want all 0",
                     core_rd_data_b, core_rd_valid_b, host_ready_b, load_done_b, busy_b,
                     rd_count_b, wr_count_b, err_addr_b);
        end
        rst = 1'b0;
        tick();
    endtask

    // Host burst from load_buf; optionally pokes the core port once mid-burst.
    task automatic do_load(input int base, input int len, input bit collide, input string name);
        int idx = 0;
        int guard = 0;
        int done_a = 0;
        int done_b = 0;
        int stray_valid = 0;
        host_base  = 12'(base);
        host_len   = 13'(len);
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        done_a += int'(load_done_a);
        done_b += int'(load_done_b);
        if (collide) begin
            core_rd_en   = 1'b1;
            core_wr_en   = 1'b1;
            core_addr    = 12'd1;
            core_wr_data = 16'hBEEF;
            err_a_m = 1;
            err_b_m = 1;
            tick();
            core_rd_en = 1'b0;
            core_wr_en = 1'b0;
            done_a += int'(load_done_a);
            done_b += int'(load_done_b);
        end
        while (idx < len && guard < 500) begin
            host_valid = 1'b0;
            if (host_ready_a && $urandom_range(0, 3) != 0) begin
                host_valid = 1'b1;
                host_data  = load_buf[idx];
                model_write(base + idx, load_buf[idx]);
                idx++;
            end
            tick();
            guard++;
            done_a += int'(load_done_a);
            done_b += int'(load_done_b);
            stray_valid += int'(core_rd_valid_a) + int'(core_rd_valid_b);
        end
        host_valid = 1'b0;
        repeat (3) begin
            tick();
            done_a += int'(load_done_a);
            done_b += int'(load_done_b);
            stray_valid += int'(core_rd_valid_a) + int'(core_rd_valid_b);
        end
        vectors++;
        if (idx != len) begin
            miscompares++;
            $display("FAIL %s_accepted: got %0d words accepted, want %0d", name, idx, len);
        end
        vectors++;
        if (done_a != 1 || done_b != 1) begin
            miscompares++;
            $display("FAIL %s_load_done: got pulses a=%0d b=%0d, want 1 each", name, done_a, done_b);
        end
        vectors++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_after: got a=%b b=%b, want 0", name, busy_a, busy_b);
        end
        vectors++;
        if (stray_valid != 0) begin
            miscompares++;
            $display("FAIL %s_no_core_valid: got %0d valid cycles, want 0", name, stray_valid);
        end
    endtask

    // Plays op_* slots one per cycle and checks every response cycle of both instances.
    task automatic play_core_ops(input int n, input string name);
        bit          ev_a [72];
        bit          ek_a [72];
        logic [15:0] ed_a [72];
        bit          ev_b [72];
        bit          ek_b [72];
        logic [15:0] ed_b [72];
        logic [15:0] da, db;
        bit          ka, kb;
        for (int i = 0; i < 72; i++) begin
            ev_a[i] = 0; ek_a[i] = 0; ed_a[i] = '0;
            ev_b[i] = 0; ek_b[i] = 0; ed_b[i] = '0;
        end
        for (int t = 0; t < n + 5; t++) begin
            tick();
            vectors++;
            if (core_rd_valid_a !== ev_a[t]) begin
                miscompares++;
                $display("FAIL %s_valid_a[%0d]: got %b, want %b", name, t, core_rd_valid_a, ev_a[t]);
            end
            if (ev_a[t] && ek_a[t]) begin
                vectors++;
                if (core_rd_data_a !== ed_a[t]) begin
                    miscompares++;
                    $display("FAIL %s_data_a[%0d]: got %h, want %h", name, t, core_rd_data_a, ed_a[t]);
                end
            end
            vectors++;
            if (core_rd_valid_b !== ev_b[t]) begin
                miscompares++;
                $display("FAIL %s_valid_b[%0d]: got %b, want %b", name, t, core_rd_valid_b, ev_b[t]);
            end
            if (ev_b[t] && ek_b[t]) begin
                vectors++;
                if (core_rd_data_b !== ed_b[t]) begin
                    miscompares++;
                    $display("FAIL %s_data_b[%0d]: got %h, want %h", name, t, core_rd_data_b, ed_b[t]);
                end
            end
            core_rd_en = 1'b0;
            core_wr_en = 1'b0;
            if (t < n) begin
                core_rd_en   = op_rd[t];
                core_wr_en   = op_wr[t];
                core_addr    = 12'(op_addr[t]);
                core_wr_data = op_data[t];
                if (op_rd[t]) begin
                    model_read(op_addr[t], da, ka, db, kb);
                    ev_a[t + LAT_A] = 1; ek_a[t + LAT_A] = ka; ed_a[t + LAT_A] = da;
                    ev_b[t + LAT_B] = 1; ek_b[t + LAT_B] = kb; ed_b[t + LAT_B] = db;
                end
                if (op_wr[t]) model_write(op_addr[t], op_data[t]);
            end
        end
        vectors++;
        if (rd_count_a !== 32'(rd_a) || wr_count_a !== 32'(wr_a) || err_addr_a !== err_a_m) begin
            miscompares++;
            $display("FAIL %s_status_a: got rc=%0d wc=%0d err=%b, want rc=%0d wc=%0d err=%b",
                     name, rd_count_a, wr_count_a, err_addr_a, rd_a, wr_a, err_a_m);
        end
        vectors++;
        if (rd_count_b !== 32'(rd_b) || wr_count_b !== 32'(wr_b) || err_addr_b !== err_b_m) begin
            miscompares++;
            $display("FAIL %s_status_b: got rc=%0d wc=%0d err=%b, want rc=%0d wc=%0d err=%b",
                     name, rd_count_b, wr_count_b, err_addr_b, rd_b, wr_b, err_b_m);
        end
    endtask

    function automatic void set_op(input int i, input bit rd, input bit wr, input int addr,
                                   input logic [15:0] d);
        op_rd[i] = rd; op_wr[i] = wr; op_addr[i] = addr; op_data[i] = d;
    endfunction

    task automatic test_load_basic();
        for (int i = 0; i < 4; i++) load_buf[i] = 16'(i + 1);
        do_load(0, 4, 0, "load_basic");
        for (int i = 0; i < 4; i++) set_op(i, 1, 0, i, '0);
        play_core_ops(4, "load_readback");
    endtask

    task automatic test_read_latency();
        for (int i = 0; i < 16; i++) load_buf[i] = 16'($urandom);
        do_load(0, 16, 0, "load16");
        for (int i = 0; i < 16; i++) set_op(i, 1, 0, i, '0);
        play_core_ops(16, "latency");
    endtask

    task automatic test_rd_wr_same_cycle();
        set_op(0, 0, 1, 5, 16'd7);
        set_op(1, 0, 0, 0, '0);
        set_op(2, 1, 1, 5, 16'hFFFD);
        set_op(3, 1, 0, 5, '0);
        play_core_ops(4, "rd_before_wr");
    endtask

    task automatic test_out_of_range();
        set_op(0, 1, 0, 40, '0);
        set_op(1, 0, 1, 40, 16'h1234);
        set_op(2, 1, 0, 40, '0);
        set_op(3, 1, 0, 31, '0);
        play_core_ops(4, "out_of_range");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int k = int'($urandom_range(0, 9));
            set_op(i, k < 5, k >= 3 && k < 8, int'($urandom_range(0, 47)), 16'($urandom));
        end
        play_core_ops(40, "random");
    endtask

    task automatic test_load_collision();
        for (int i = 0; i < 2; i++) load_buf[i] = 16'($urandom);
        do_load(100, 2, 1, "load_collide");
        set_op(0, 1, 0, 1, '0);
        set_op(1, 1, 0, 100, '0);
        set_op(2, 1, 0, 101, '0);
        play_core_ops(3, "collide_readback");
    endtask

    task automatic test_reset_mid_load();
        int accepted = 0;
        int guard = 0;
        int done_seen = 0;
        for (int i = 0; i < 4; i++) load_buf[i] = 16'($urandom);
        host_base  = 12'd200;
        host_len   = 13'd4;
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        while (accepted < 2 && guard < 50) begin
            host_valid = 1'b0;
            if (host_ready_a) begin
                host_valid = 1'b1;
                host_data  = load_buf[accepted];
                model_write(200 + accepted, load_buf[accepted]);
                accepted++;
            end
            tick();
            guard++;
        end
        host_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0; err_a_m = 0; err_b_m = 0;
        vectors++;
        if (accepted != 2 || busy_a !== 1'b0 || host_ready_a !== 1'b0 || busy_b !== 1'b0 || host_ready_b !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_reset_idle: got acc=%0d busy=%b/%b ready=%b/%b, want 2 and 0",
                     accepted, busy_a, busy_b, host_ready_a, host_ready_b);
        end
        vectors++;
        if ({rd_count_a, wr_count_a, err_addr_a, rd_count_b, wr_count_b, err_addr_b} !== '0) begin
            miscompares++;
            $display("FAIL midload_reset_status: got rc=%0d wc=%0d err=%b / rc=%0d wc=%0d err=%b, want 0",
                     rd_count_a, wr_count_a, err_addr_a, rd_count_b, wr_count_b, err_addr_b);
        end
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            done_seen += int'(load_done_a) + int'(load_done_b) + int'(busy_a) + int'(busy_b);
        end
        vectors++;
        if (done_seen != 0) begin
            miscompares++;
            $display("FAIL midload_no_done: got %0d done/busy cycles, want 0", done_seen);
        end
        set_op(0, 1, 0, 200, '0);
        set_op(1, 1, 0, 201, '0);
        set_op(2, 1, 0, 5, '0);
        play_core_ops(3, "midload_readback");
    endtask

    initial begin
        for (int i = 0; i < DEPTH_A; i++) known_a[i] = 0;
        for (int i = 0; i < DEPTH_B; i++) known_b[i] = 0;
        test_reset();
        test_load_basic();
        test_read_latency();
        test_rd_wr_same_cycle();
        test_out_of_range();
        test_random();
        test_load_collision();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
